// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle
// through a shared XLEN+1-bit adder, with sign fix-up and divide fast paths.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StCalc = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   mag_q, mag_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            is_div, sign_a, sign_b, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;
  logic [XLEN:0]   add_a, add_b;
  logic            add_cin, no_borrow;
  logic [XLEN+1:0] add_sum;
  logic [2*XLEN-1:0] prod_neg, step;
  logic [XLEN-1:0]   lo_fix, hi_fix, rem_fix, fix_res;

  assign is_div = f3_q[2];
  assign sign_a = a_q[XLEN-1] &
                  (is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10));
  assign sign_b = b_q[XLEN-1] & (is_div ? ~f3_q[0] : (f3_q[1:0] == 2'b01));
  assign abs_a  = sign_a ? -a_q : a_q;
  assign abs_b  = sign_b ? -b_q : b_q;
  assign div0   = is_div && (b_q == '0);
  assign ovf    = is_div && !f3_q[0] && (a_q == MinInt) && (b_q == '1);
  // REM/REMU take the dividend on divide-by-zero; quotients saturate to all ones.
  assign fast_res = div0 ? (f3_q[1] ? a_q : '1) : (f3_q[1] ? '0 : a_q);

  // Shared adder: accumulate for multiply, trial subtract (a + ~b + 1) for divide.
  always_comb begin
    if (is_div) begin
      add_a   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
      add_b   = ~{1'b0, mag_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, prod_q[2*XLEN-1:XLEN]};
      add_b   = prod_q[0] ? {1'b0, mag_q} : '0;
      add_cin = 1'b0;
    end
  end

  assign add_sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, add_cin};
  assign no_borrow = add_sum[XLEN+1];

  always_comb begin
    if (is_div) begin
      step = {(no_borrow ? add_sum[XLEN-1:0] : add_a[XLEN-1:0]),
              prod_q[XLEN-2:0], no_borrow};
    end else begin
      step = {add_sum[XLEN:0], prod_q[XLEN-1:1]};
    end
  end

  // Quotient negation uses the low half of the full negated register; remainder negates alone.
  assign prod_neg = -prod_q;
  assign lo_fix   = neg_q ? prod_neg[XLEN-1:0] : prod_q[XLEN-1:0];
  assign hi_fix   = neg_q ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
  assign rem_fix  = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = lo_fix;
    case (f3_q)
      3'b001, 3'b010, 3'b011: fix_res = hi_fix;
      3'b110, 3'b111:         fix_res = rem_fix;
      default:                fix_res = lo_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    mag_d    = mag_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          f3_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
          state_d = StPrep;
        end else begin
          state_d = StIdle;
        end
      end
      StPrep: begin
        if (div0 || ovf) begin
          result_d = fast_res;
          state_d  = StDone;
        end else begin
          mag_d   = is_div ? abs_b : abs_a;
          prod_d  = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
          neg_d   = (is_div && f3_q[1]) ? sign_a : (sign_a ^ sign_b);
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        prod_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        result_d = fix_res;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_q    <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mag_q    <= mag_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy   = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
